// File: rtl/vga_draw_pkg.sv
// Shared drawing constants, FSM encoding and clip helpers for the VGA draw blocks.
package vga_draw_pkg;

   localparam int SCREEN_W    = 160;
   localparam int SCREEN_H    = 120;
   localparam int X_BITS      = 8;
   localparam int Y_BITS      = 7;
   localparam int COLOUR_BITS = 3;

   // EMPTY covers commands that clip to nothing; it only produces the done pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DONE  = 2'd2,
      EMPTY = 2'd3
   } draw_state_t;

   // Visible width of a span starting at x0; one extra bit so SCREEN_W-x0 cannot wrap.
   function automatic logic [X_BITS-1:0] clip_w(input logic [X_BITS-1:0] x0,
                                                input logic [X_BITS-1:0] w);
      logic [X_BITS:0] lim;
      logic [X_BITS:0] org;
      logic [X_BITS:0] room;
      lim  = (X_BITS+1)'(SCREEN_W);
      org  = {1'b0, x0};
      room = lim - org;
      if (org >= lim)
         return '0;
      else if ({1'b0, w} < room)
         return w;
      else
         return room[X_BITS-1:0];
   endfunction

   // Visible height of a span starting at y0.
   function automatic logic [Y_BITS-1:0] clip_h(input logic [Y_BITS-1:0] y0,
                                                input logic [Y_BITS-1:0] h);
      logic [Y_BITS:0] lim;
      logic [Y_BITS:0] org;
      logic [Y_BITS:0] room;
      lim  = (Y_BITS+1)'(SCREEN_H);
      org  = {1'b0, y0};
      room = lim - org;
      if (org >= lim)
         return '0;
      else if ({1'b0, h} < room)
         return h;
      else
         return room[Y_BITS-1:0];
   endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// 2-D raster walker: loads an origin and non-zero extents, steps x then y,
// and flags the bottom-right dot of the loaded rectangle.
module vga_raster_counter
   import vga_draw_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              load,
   input  logic              advance,
   input  logic [X_BITS-1:0] x0,
   input  logic [Y_BITS-1:0] y0,
   input  logic [X_BITS-1:0] ew,
   input  logic [Y_BITS-1:0] eh,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic              last
);

   localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
   localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);

   logic [X_BITS-1:0] x_base;
   logic [X_BITS-1:0] x_end;
   logic [Y_BITS-1:0] y_end;

   // Store inclusive end coordinates so the wrap/last tests are plain compares.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_base <= '0;
         x_end  <= '0;
         y_end  <= '0;
      end else if (load) begin
         x_base <= x0;
         x_end  <= x0 + ew - X_ONE;
         y_end  <= y0 + eh - Y_ONE;
      end
   end

   // Position walks raster order; it holds whenever neither load nor advance is set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x <= '0;
         y <= '0;
      end else if (load) begin
         x <= x0;
         y <= y0;
      end else if (advance) begin
         if (x == x_end) begin
            x <= x_base;
            y <= y + Y_ONE;
         end else begin
            x <= x + X_ONE;
         end
      end
   end

   // Last dot of the rectangle is currently presented.
   always_comb begin
      last = (x == x_end) && (y == y_end);
   end

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: latches a clipped command, then emits one plotted
// dot per clock in raster order and pulses done once the rectangle is covered.
module vga_rect_filler
   import vga_draw_pkg::*;
(
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [X_BITS-1:0]      x0,
   input  logic [Y_BITS-1:0]      y0,
   input  logic [X_BITS-1:0]      width,
   input  logic [Y_BITS-1:0]      height,
   input  logic [COLOUR_BITS-1:0] colour,
   output logic [X_BITS-1:0]      x,
   output logic [Y_BITS-1:0]      y,
   output logic [COLOUR_BITS-1:0] colour_out,
   output logic                   plot,
   output logic                   busy,
   output logic                   done
);

   draw_state_t       state;
   logic [X_BITS-1:0] ew;
   logic [Y_BITS-1:0] eh;
   logic              cmd_empty;
   logic              accept;
   logic              cnt_load;
   logic              cnt_adv;
   logic              last_dot;

   // Clip the live command; only consulted on the accepting edge.
   always_comb begin
      ew        = clip_w(x0, width);
      eh        = clip_h(y0, height);
      cmd_empty = (ew == '0) || (eh == '0);
      accept    = (state == IDLE) && start;
      cnt_load  = accept && !cmd_empty;
      cnt_adv   = (state == FILL) && !last_dot;
   end

   vga_raster_counter u_raster (
      .clock   (clock),
      .resetn  (resetn),
      .load    (cnt_load),
      .advance (cnt_adv),
      .x0      (x0),
      .y0      (y0),
      .ew      (ew),
      .eh      (eh),
      .x       (x),
      .y       (y),
      .last    (last_dot)
   );

   // Command FSM with registered handshake, plot and colour outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         colour_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  colour_out <= colour;
                  busy       <= 1'b1;
                  if (cmd_empty) begin
                     state <= EMPTY;
                     done  <= 1'b1;
                  end else begin
                     state <= FILL;
                     plot  <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (last_dot) begin
                  state <= DONE;
                  plot  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE, EMPTY: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               plot  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Bench for vga_rect_filler: table vectors, random commands against a dot-list
// model, and hand sequences for back-to-back start and reset abort.
module tb_vga_rect_filler;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] x0, width;
   logic [6:0] y0, height;
   logic [2:0] colour;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour_out;
   logic       plot, busy, done;

   int nvec = 0;
   int nmis = 0;

   typedef struct {int x; int y;} dot_t;
   dot_t exp_q[$];

   typedef struct {
      int x0; int y0; int w; int h; int col;
      int exp_n; int exp_lx; int exp_ly;
   } vec_t;
   vec_t tbl[10];

   vga_rect_filler dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .x0         (x0),
      .y0         (y0),
      .width      (width),
      .height     (height),
      .colour     (colour),
      .x          (x),
      .y          (y),
      .colour_out (colour_out),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: walk the unclipped rectangle and keep only on-screen dots.
   task automatic build_model(input int ax0, input int ay0, input int aw, input int ah);
      exp_q.delete();
      for (int r = 0; r < ah; r++)
         for (int c = 0; c < aw; c++)
            if (ax0 + c < 160 && ay0 + r < 120)
               exp_q.push_back('{ax0 + c, ay0 + r});
   endtask

   // Issue one command from IDLE (called at a negedge) and follow it to IDLE.
   task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                          input int acol, input bit hold,
                          output int np, output int lx, output int ly);
      int   n;
      int   dc;
      dot_t d;
      build_model(ax0, ay0, aw, ah);
      n  = exp_q.size();
      np = 0; lx = -1; ly = -1; dc = -1;
      x0 = 8'(ax0); y0 = 7'(ay0); width = 8'(aw); height = 7'(ah);
      colour = 3'(acol); start = 1'b1;
      @(negedge clock);
      for (int c = 1; c <= n + 4; c++) begin
         if (plot) begin
            np++;
            lx = x; ly = y;
            chk("colour_out", colour_out, acol);
            if (exp_q.size() > 0) begin
               d = exp_q.pop_front();
               chk("dot_x", x, d.x);
               chk("dot_y", y, d.y);
            end else begin
               chk("extra_plot", np, n);
            end
         end
         chk("busy_during_cmd", busy, 1);
         if (done) begin
            dc = c;
            break;
         end
         // Inputs are scrambled while busy; start is either held or random.
         start  = hold ? 1'b1 : 1'($urandom_range(0, 1));
         x0     = 8'($urandom);
         y0     = 7'($urandom);
         width  = 8'($urandom);
         height = 7'($urandom);
         colour = 3'($urandom);
         @(negedge clock);
      end
      start = 1'b0;
      chk("done_cycle", dc, n + 1);
      chk("plot_count", np, n);
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_plot", plot, 0);
      if (np > 0) begin
         chk("x_hold", x, lx);
         chk("y_hold", y, ly);
      end
   endtask

   initial begin
      int np, lx, ly, cnt;
      resetn = 1'b0; start = 1'b0;
      x0 = '0; y0 = '0; width = '0; height = '0; colour = '0;

      tbl[0] = '{10, 5, 2, 2, 5, 4, 11, 6};
      tbl[1] = '{158, 118, 4, 4, 2, 4, 159, 119};
      tbl[2] = '{20, 30, 0, 5, 7, 0, 0, 0};
      tbl[3] = '{200, 10, 5, 5, 1, 0, 0, 0};
      tbl[4] = '{3, 119, 4, 1, 6, 4, 6, 119};
      tbl[5] = '{159, 0, 1, 3, 4, 3, 159, 2};
      tbl[6] = '{5, 120, 3, 3, 1, 0, 0, 0};
      tbl[7] = '{40, 50, 3, 1, 2, 3, 42, 50};
      tbl[8] = '{150, 100, 255, 127, 3, 200, 159, 119};
      tbl[9] = '{0, 0, 160, 120, 1, 19200, 159, 119};

      repeat (2) @(negedge clock);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour_out, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      resetn = 1'b1;
      @(negedge clock);

      // Table vectors; odd entries hold start high through the whole command.
      for (int i = 0; i < 10; i++) begin
         run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col, 1'(i % 2),
                 np, lx, ly);
         chk("tbl_plots", np, tbl[i].exp_n);
         if (tbl[i].exp_n > 0) begin
            chk("tbl_last_x", lx, tbl[i].exp_lx);
            chk("tbl_last_y", ly, tbl[i].exp_ly);
         end
      end

      // Random commands, biased to straddle the right and bottom screen edges.
      for (int i = 0; i < 30; i++) begin
         int rx, ry;
         rx = ($urandom_range(0, 3) == 0) ? $urandom_range(140, 255) : $urandom_range(0, 159);
         ry = ($urandom_range(0, 3) == 0) ? $urandom_range(105, 127) : $urandom_range(0, 119);
         run_cmd(rx, ry, $urandom_range(0, 40), $urandom_range(0, 30),
                 $urandom_range(0, 7), 1'b0, np, lx, ly);
      end

      // Back-to-back: start held from the DONE cycle triggers at the edge after IDLE.
      x0 = 8'd10; y0 = 7'd10; width = 8'd1; height = 7'd1; colour = 3'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("b2b_plot_a", plot, 1);
      chk("b2b_xa", x, 10);
      chk("b2b_ya", y, 10);
      @(negedge clock);
      chk("b2b_done_a", done, 1);
      x0 = 8'd30; y0 = 7'd40; width = 8'd2; height = 7'd1; colour = 3'd6; start = 1'b1;
      @(negedge clock);
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_plot", plot, 0);
      chk("b2b_idle_done", done, 0);
      @(negedge clock);
      start = 1'b0;
      chk("b2b_plot_b", plot, 1);
      chk("b2b_xb0", x, 30);
      chk("b2b_yb0", y, 40);
      chk("b2b_colour_b", colour_out, 6);
      @(negedge clock);
      chk("b2b_xb1", x, 31);
      @(negedge clock);
      chk("b2b_done_b", done, 1);
      chk("b2b_plot_off", plot, 0);
      @(negedge clock);
      chk("b2b_end_busy", busy, 0);

      // Reset at the third dot of a 4x4 aborts at once with no done afterwards.
      x0 = 8'd60; y0 = 7'd60; width = 8'd4; height = 7'd4; colour = 3'd6; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("abort_third_x", x, 62);
      chk("abort_third_plot", plot, 1);
      resetn = 1'b0;
      #1;
      chk("abort_plot", plot, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clock);
      resetn = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         cnt += int'(done) + int'(busy) + int'(plot);
      end
      chk("abort_quiet", cnt, 0);
      run_cmd(70, 20, 3, 2, 5, 1'b0, np, lx, ly);
      chk("after_abort_plots", np, 6);
      chk("after_abort_last_x", lx, 72);
      chk("after_abort_last_y", ly, 21);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
